disp_pixel_fetch: RTL and testbench



---
 rtl/disp_pixel_fetch_if.sv | 12 +
 rtl/disp_pixel_fetch.sv | 147 ++++++++++++++
 tb/tb_disp_pixel_fetch.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/disp_pixel_fetch_if.sv
// Frame-memory read port: the fetch stage drives strobe/address, the memory returns data RD_LAT cycles later.
interface disp_pixel_fetch_if #(
    parameter int AW = 12,
    parameter int DW = 24
);
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/disp_pixel_fetch.sv
// disp_pixel_fetch: sync stream -> one frame-memory read per active pixel -> aligned RGB; BMP_BOTTOM_UP_EN fetches rows bottom-up.
// Latency RD_LAT+1 cycles (i_de->o_de, read->o_rgb); no backpressure, memory must accept one read per cycle.
module disp_pixel_fetch #(
    parameter int HRES   = 4,
    parameter int VRES   = 4,
    parameter int DW     = 24,
    parameter int AW     = 12,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              rst_n,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic              i_de,
    disp_pixel_fetch_if.master mem,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_de,
    output logic [DW-1:0]     o_rgb,
    output logic              o_line_err
);
    localparam int CW = $clog2(HRES + 1);
    localparam int RW = $clog2(VRES + 1);
    localparam logic [CW-1:0] HRES_C  = CW'(HRES);
    localparam logic [RW-1:0] VRES_R  = RW'(VRES);
    localparam logic [RW-1:0] VLAST_R = RW'(VRES - 1);
    localparam logic [AW-1:0] HRES_A  = AW'(HRES);
`ifdef BMP_BOTTOM_UP_EN
    localparam logic [AW-1:0] BASE0 = AW'((VRES - 1) * HRES);
`else
    localparam logic [AW-1:0] BASE0 = '0;
`endif

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic rd;
    } sync_t;

    logic          vsync_q, de_q;
    logic          armed_q, armed_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          line_err_q, line_err_d;
    sync_t [RD_LAT-1:0] pipe_q;
    sync_t         out_q, stage_in;
    logic [DW-1:0] rgb_q;

    logic vs_rise, de_fall, rd_en;

    assign vs_rise = i_vsync & ~vsync_q;
    assign de_fall = de_q & ~i_de;
    assign rd_en   = i_de & armed_q & (col_q < HRES_C) & (row_q < VRES_R);

    // ovf marks a line that kept i_de high past HRES; col alone saturates and cannot show it.
    always_comb begin
        armed_d    = armed_q;
        ovf_d      = ovf_q;
        col_d      = col_q;
        row_d      = row_q;
        base_d     = base_q;
        line_err_d = 1'b0;
        if (vs_rise) begin
            armed_d = 1'b1;
            ovf_d   = 1'b0;
            col_d   = '0;
            row_d   = '0;
            base_d  = BASE0;
        end else if (armed_q) begin
            if (rd_en) begin
                col_d = col_q + 1'b1;
            end else if (i_de) begin
                ovf_d = 1'b1;
            end
            if (de_fall) begin
                line_err_d = ovf_q | (col_q != HRES_C) | (row_q >= VRES_R);
                col_d      = '0;
                ovf_d      = 1'b0;
                if (row_q < VRES_R) begin
                    row_d = row_q + 1'b1;
                end
                // Only step the base while another active line follows, so it never wraps.
                if (row_q < VLAST_R) begin
`ifdef BMP_BOTTOM_UP_EN
                    base_d = base_q - HRES_A;
`else
                    base_d = base_q + HRES_A;
`endif
                end
            end
        end
        addr_d = base_d + AW'(col_d);
    end

    always_comb begin
        stage_in    = '0;
        stage_in.hs = i_hsync;
        stage_in.vs = i_vsync;
        stage_in.de = i_de & armed_q;
        stage_in.rd = rd_en;
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            de_q       <= 1'b0;
            armed_q    <= 1'b0;
            ovf_q      <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            base_q     <= BASE0;
            addr_q     <= BASE0;
            line_err_q <= 1'b0;
            pipe_q     <= '0;
            out_q      <= '0;
            rgb_q      <= '0;
        end else begin
            vsync_q    <= i_vsync;
            de_q       <= i_de;
            armed_q    <= armed_d;
            ovf_q      <= ovf_d;
            col_q      <= col_d;
            row_q      <= row_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            line_err_q <= line_err_d;
            pipe_q[0]  <= stage_in;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            out_q <= pipe_q[RD_LAT-1];
            rgb_q <= pipe_q[RD_LAT-1].rd ? mem.rd_data : '0;
        end
    end

    assign mem.rd_en   = rd_en;
    assign mem.rd_addr = addr_q;
    assign o_hsync     = out_q.hs;
    assign o_vsync     = out_q.vs;
    assign o_de        = out_q.de;
    assign o_rgb       = rgb_q;
    assign o_line_err  = line_err_q;
endmodule

// File: tb/tb_disp_pixel_fetch.sv
// Bench: two fetch instances (RD_LAT 1 and 3) on one random sync stream, checked against a line/pixel-count model.
module tb_disp_pixel_fetch;
    localparam int HRES = 4;
    localparam int VRES = 4;
    localparam int DW   = 24;
    localparam int AW   = 12;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0;
    always #5 clk = ~clk;

    disp_pixel_fetch_if #(.AW(AW), .DW(DW)) mem1 ();
    disp_pixel_fetch_if #(.AW(AW), .DW(DW)) mem3 ();

    logic o_hs1, o_vs1, o_de1, o_err1, o_hs3, o_vs3, o_de3, o_err3;
    logic [DW-1:0] o_rgb1, o_rgb3;

    disp_pixel_fetch #(.HRES(HRES), .VRES(VRES), .DW(DW), .AW(AW), .RD_LAT(1)) u_dut1 (
        .i_clk(clk), .rst_n(rst_n), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
        .mem(mem1), .o_hsync(o_hs1), .o_vsync(o_vs1), .o_de(o_de1), .o_rgb(o_rgb1),
        .o_line_err(o_err1));

    disp_pixel_fetch #(.HRES(HRES), .VRES(VRES), .DW(DW), .AW(AW), .RD_LAT(3)) u_dut3 (
        .i_clk(clk), .rst_n(rst_n), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
        .mem(mem3), .o_hsync(o_hs3), .o_vsync(o_vs3), .o_de(o_de3), .o_rgb(o_rgb3),
        .o_line_err(o_err3));

    // Memory returns data = addr on a read, a poison pattern otherwise.
    logic [DW-1:0] m1_q;
    logic [DW-1:0] m3_q [3];
    always @(posedge clk) begin
        m1_q    <= mem1.rd_en ? {12'h000, mem1.rd_addr} : 24'hA5A5A5;
        m3_q[0] <= mem3.rd_en ? {12'h000, mem3.rd_addr} : 24'hA5A5A5;
        m3_q[1] <= m3_q[0];
        m3_q[2] <= m3_q[1];
    end
    assign mem1.rd_data = m1_q;
    assign mem3.rd_data = m3_q[2];

    int n_assert = 0, n_fail = 0, cyc = 0, base_cyc = 0;
    bit h_hs [MAXC], h_vs [MAXC], h_de [MAXC], h_rd [MAXC], h_err [MAXC];
    int h_addr [MAXC];
    bit m_armed = 1'b0, m_prev_vs = 1'b0, m_prev_de = 1'b0;
    int m_len = 0, m_line = 0;

    function automatic int line_addr(input int l);
`ifdef BMP_BOTTOM_UP_EN
        return (VRES - 1 - l) * HRES;
`else
        return l * HRES;
`endif
    endfunction

    function automatic int pidx(input int k);
        int i = cyc - k;
        return (i < base_cyc) ? -1 : i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_out(input string tag, input int lat, input logic hs, input logic vs,
                           input logic de, input logic [DW-1:0] rgb, input logic err);
        int i = pidx(lat + 1);
        int j = pidx(1);
        int ehs = 0, evs = 0, ede = 0, ergb = 0, eerr = 0;
        if (i >= 0) begin
            ehs  = int'(h_hs[i]);
            evs  = int'(h_vs[i]);
            ede  = int'(h_de[i]);
            ergb = h_rd[i] ? h_addr[i] : 0;
        end
        if (j >= 0) eerr = int'(h_err[j]);
        chk({tag, "_hsync"}, 32'(hs), 32'(ehs));
        chk({tag, "_vsync"}, 32'(vs), 32'(evs));
        chk({tag, "_de"}, 32'(de), 32'(ede));
        chk({tag, "_rgb"}, 32'(rgb), 32'(ergb));
        chk({tag, "_line_err"}, 32'(err), 32'(eerr));
    endtask

    // Called at posedge+1: drive one cycle, check at the falling edge, advance the model.
    task automatic tick(input int vs, input int hs, input int de);
        bit vsb = (vs != 0), hsb = (hs != 0), deb = (de != 0);
        bit vs_rise, de_fall, e_rd, e_err;
        int e_addr;
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget: cycle %0d reached limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        i_vsync = vsb; i_hsync = hsb; i_de = deb;
        @(negedge clk);
        vs_rise = vsb && !m_prev_vs;
        de_fall = !deb && m_prev_de;
        e_rd    = deb && m_armed && (m_len < HRES) && (m_line < VRES);
        e_addr  = line_addr(m_line) + m_len;
        e_err   = m_armed && de_fall && !vs_rise && ((m_len != HRES) || (m_line >= VRES));
        chk("rd_en_l1", 32'(mem1.rd_en), 32'(e_rd));
        chk("rd_en_l3", 32'(mem3.rd_en), 32'(e_rd));
        if (e_rd) begin
            chk("rd_addr_l1", 32'(mem1.rd_addr), 32'(e_addr));
            chk("rd_addr_l3", 32'(mem3.rd_addr), 32'(e_addr));
        end
        chk_out("l1", 1, o_hs1, o_vs1, o_de1, o_rgb1, o_err1);
        chk_out("l3", 3, o_hs3, o_vs3, o_de3, o_rgb3, o_err3);
        h_hs[cyc] = hsb; h_vs[cyc] = vsb; h_de[cyc] = deb && m_armed;
        h_rd[cyc] = e_rd; h_addr[cyc] = e_addr; h_err[cyc] = e_err;
        if (vs_rise) begin
            m_armed = 1'b1; m_len = 0; m_line = 0;
        end else if (m_armed) begin
            if (deb) m_len++;
            if (de_fall) begin
                m_len = 0;
                if (m_line < VRES) m_line++;
            end
        end
        m_prev_vs = vsb; m_prev_de = deb;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_vsync = 1'b0; i_hsync = 1'b0; i_de = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_rd_en_l1", 32'(mem1.rd_en), 32'd0);
        chk("rst_rd_en_l3", 32'(mem3.rd_en), 32'd0);
        chk("rst_rd_addr_l1", 32'(mem1.rd_addr), 32'(line_addr(0)));
        chk("rst_out_l1", {27'd0, o_hs1, o_vs1, o_de1, o_err1, |o_rgb1}, 32'd0);
        chk("rst_out_l3", {27'd0, o_hs3, o_vs3, o_de3, o_err3, |o_rgb3}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_armed = 1'b0; m_prev_vs = 1'b0; m_prev_de = 1'b0; m_len = 0; m_line = 0;
        base_cyc = cyc;
    endtask

    task automatic line(input int len);
        int g = int'($urandom_range(0, 2));
        tick(0, 1, 0);
        for (int k = 0; k < g; k++) tick(0, 0, 0);
        for (int k = 0; k < len; k++) tick(0, 0, 1);
    endtask

    task automatic vframe();
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
    endtask

    initial begin
        #2;
        do_reset();
        // Lines before any vsync: no reads, no o_de, syncs still propagate.
        line(HRES); line(HRES); tick(0, 0, 0);
        // Normal frame.
        vframe();
        for (int l = 0; l < VRES; l++) line(HRES);
        // Short first line.
        vframe();
        line(3);
        for (int l = 1; l < VRES; l++) line(HRES);
        // Long first line, then an excess line beyond VRES.
        vframe();
        line(5);
        for (int l = 1; l <= VRES; l++) line(HRES);
        tick(0, 0, 0);
        // Random frames with line lengths around HRES.
        for (int f = 0; f < 4; f++) begin
            int nl = int'($urandom_range(3, 6));
            vframe();
            for (int l = 0; l < nl; l++) line(int'($urandom_range(HRES - 1, HRES + 1)));
        end
        // Reset in the middle of line 2, then a fresh frame.
        vframe();
        line(HRES); line(HRES);
        tick(0, 1, 0); tick(0, 0, 1); tick(0, 0, 1);
        do_reset();
        tick(0, 0, 1); tick(0, 0, 0);
        vframe();
        for (int l = 0; l < VRES; l++) line(HRES);
        for (int k = 0; k < 6; k++) tick(0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
